// File: rtl/runlen_sched.sv
`default_nettype none
// ============================================================================
// Module   : runlen_sched
// Brief    : Round-robin scheduler sharing one saturating run-length counter
//            among NCH pulse requesters; results leave over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module runlen_sched #(
    parameter int NCH     = 4,
    parameter int CW      = 5,
    parameter int MIN_LEN = 4,
    parameter int MAX_LEN = 20
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NCH-1:0]           a,
    input  logic                     en,
    input  logic                     res_ready,
    output logic                     res_valid,
    output logic [$clog2(NCH)-1:0]   res_ch,
    output logic [CW-1:0]            res_len,
    output logic                     res_hit,
    output logic                     res_sat,
    output logic                     busy,
    output logic [NCH-1:0]           miss
);

    localparam int            CHW    = $clog2(NCH);
    localparam logic [CW-1:0] SAT_V  = '1;
    localparam logic [CW-1:0] SAT_M1 = SAT_V - CW'(1);
    localparam logic [CW-1:0] MIN_L  = CW'(MIN_LEN);
    localparam logic [CW-1:0] MAX_L  = CW'(MAX_LEN);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        REPORT  = 2'd2
    } state_t;

    state_t           state;
    logic [NCH-1:0]   a_q;
    logic [NCH-1:0]   pending;
    logic [CHW-1:0]   last_grant;
    logic [CHW-1:0]   g;
    logic [CW-1:0]    cnt;

    logic [NCH-1:0]   rise;
    logic [NCH-1:0]   clr;
    logic [CHW-1:0]   idx;
    logic [CHW-1:0]   sel;
    logic             found;
    logic             grant;
    logic             meas_done;
    logic [CW-1:0]    fin_len;
    logic             fin_sat;

    // Scan from farthest to nearest so the nearest pending channel after
    // last_grant is the one left in sel.
    always_comb begin
        rise  = a & ~a_q;
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int k = NCH; k >= 1; k--) begin
            idx = CHW'((int'(last_grant) + k) % NCH);
            if (pending[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
        grant = (state == IDLE) && en && found;
        clr   = '0;
        if (grant) begin
            clr[sel] = 1'b1;
        end
        fin_sat   = a[g];
        fin_len   = a[g] ? SAT_V : cnt;
        meas_done = !a[g] || (cnt == SAT_M1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            a_q        <= '0;
            pending    <= '0;
            miss       <= '0;
            cnt        <= '0;
            g          <= '0;
            last_grant <= CHW'(NCH - 1);
            res_valid  <= 1'b0;
            res_ch     <= '0;
            res_len    <= '0;
            res_hit    <= 1'b0;
            res_sat    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            a_q     <= a;
            miss    <= miss | (rise & pending);
            // A rise on the channel being granted re-posts it.
            pending <= (pending & ~clr) | rise;

            case (state)
                IDLE: begin
                    if (grant) begin
                        g          <= sel;
                        last_grant <= sel;
                        cnt        <= '0;
                        state      <= MEASURE;
                        busy       <= 1'b1;
                    end
                end
                MEASURE: begin
                    if (meas_done) begin
                        cnt       <= fin_len;
                        res_valid <= 1'b1;
                        res_ch    <= g;
                        res_len   <= fin_len;
                        res_sat   <= fin_sat;
                        res_hit   <= (fin_len >= MIN_L) && (fin_len <= MAX_L);
                        state     <= REPORT;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                REPORT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
